input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//   Cleans a raw asynchronous level input before it reaches the pattern-detector FSMs.
//   - Synchronises the input.
//   - Filters glitches shorter than STABLE_CYCLES.
//   - Produces a clean level plus one-cycle rise/fall pulses.
//   - Sits directly upstream of the pattern detectors. a_clean drives their 'a' input.
// PARAMETERS
//   STABLE_CYCLES  4  consecutive synchronised samples required to commit a new level; legal range 2..255
//   GLITCH_W       8  width of the saturating glitch counter
// PORTS
//   clk        input   1         single clock; all state updates on posedge clk
//   reset      input   1         synchronous, active-low reset (0 = reset, sampled on posedge clk)
//   a_raw      input   1         raw asynchronous level input
//   a_clean    output  1         debounced level
//   rise       output  1         1-cycle pulse when a_clean goes 0->1
//   fall       output  1         1-cycle pulse when a_clean goes 1->0
//   glitch_cnt output  GLITCH_W  count of aborted level changes; saturates at all-ones
// BEHAVIOUR
//   Reset (reset==0 at posedge clk)
//     - sync1 = 0, sync2 = 0, state = LOW, cnt = 0.
//     - Outputs: a_clean = 0, rise = 0, fall = 0, glitch_cnt = 0.
//     - Reset has priority over all other activity, including mid-WAIT. No pulse is emitted on reset.
//   Synchroniser
//     - Two flops: sync1 <= a_raw, sync2 <= sync1. s = sync2.
//     - The FSM acts on s only; a_raw is never used directly.
//   Counter and states
//     - cnt is $clog2(STABLE_CYCLES+1) bits.
//     - States: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
//   Transitions, evaluated each posedge
//     LOW:       s=1 -> WAIT_HIGH, cnt<=1.
//                s=0 -> stay.
//     WAIT_HIGH: s=0 -> LOW, cnt<=0, glitch_cnt++.
//                s=1 and cnt==STABLE_CYCLES-1 -> HIGH, cnt<=0, rise<=1.
//                else cnt++.
//     HIGH:      s=0 -> WAIT_LOW, cnt<=1.
//                s=1 -> stay.
//     WAIT_LOW:  s=1 -> HIGH, cnt<=0, glitch_cnt++.
//                s=0 and cnt==STABLE_CYCLES-1 -> LOW, cnt<=0, fall<=1.
//                else cnt++.
//   Outputs
//     - a_clean is registered: 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH.
//       It changes on the same edge that sets rise or fall.
//     - rise and fall are registered. Each is high for exactly one cycle, aligned with the
//       first cycle of the new a_clean level. They are never high together.
//     - glitch_cnt increments by 1 per aborted WAIT, holds at 2^GLITCH_W-1, and has no wrap.
//   Latency
//     - a_raw is stable from edge E0 onward.
//     - a_clean changes after edge E(STABLE_CYCLES+1).
//     - With STABLE_CYCLES=4: changes on the 6th edge, counting E0 as the 1st.
//   Glitch filtering
//     - A pulse on s shorter than STABLE_CYCLES samples never changes a_clean.
//   Fixed behaviour
//     - Unused state encodings go to LOW with cnt = 0.
//     - Outputs are not combinationally dependent on a_raw.
// TESTING
//   1. Reset with a_raw=1 held, release at edge E0
//      -> a_clean=0 through E0.
//      -> WAIT_HIGH entered at E2, rise=1 for one cycle after E5, a_clean=1 from E5 (STABLE_CYCLES=4).
//   2. From LOW: a_raw 1 for 3 cycles, then 0
//      -> a_clean stays 0, rise never asserts, glitch_cnt=1.
//   3. From HIGH: a_raw 0 for 4+ cycles
//      -> fall=1 for exactly one cycle, a_clean=0 on the same cycle.
//      -> rise=0 throughout, glitch_cnt unchanged.
//   4. Bounce train 1,0,1,0 (1 cycle each), then steady 1
//      -> exactly one rise. glitch_cnt equals the number of aborted WAITs (2 with this train).
//   5. Drive 300 aborted WAITs with GLITCH_W=8
//      -> glitch_cnt saturates at 255 and stays at 255.
//   6. Assert reset while in WAIT_LOW with cnt=2
//      -> next cycle: a_clean=0, rise=fall=0, glitch_cnt=0, state LOW.

Source files
------------

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a four-state debounce FSM that commits a new level
// only after STABLE_CYCLES matching samples, with rise/fall pulses and a glitch counter.
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_raw,
  output logic                a_clean,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [1:0]          sync_reg;
  logic                s;
  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [GLITCH_W-1:0] glitch_reg, glitch_next;
  logic                rise_reg, rise_next;
  logic                fall_reg, fall_next;
  logic                a_clean_reg, a_clean_next;
  logic                glitch_inc;

  assign s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg    <= 2'b00;
      state_reg   <= LOW;
      cnt_reg     <= '0;
      glitch_reg  <= '0;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
      a_clean_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], a_raw};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      glitch_reg  <= glitch_next;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      a_clean_reg <= a_clean_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    glitch_inc = 1'b0;
    case (state_reg)
      LOW: begin
        if (s) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_next = LOW;
          cnt_next   = '0;
          glitch_inc = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_next = HIGH;
          cnt_next   = '0;
          glitch_inc = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase

    // Saturate rather than wrap so a long bounce history stays visibly "many".
    glitch_next = glitch_reg;
    if (glitch_inc && (glitch_reg != '1))
      glitch_next = glitch_reg + GLITCH_ONE;

    a_clean_next = (state_next == HIGH) || (state_next == WAIT_LOW);
  end

  assign a_clean    = a_clean_reg;
  assign rise       = rise_reg;
  assign fall       = fall_reg;
  assign glitch_cnt = glitch_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised bench for input_debouncer: a run-length reference model checked every cycle,
// plus directed scenarios pinned with literal expectations.
module tb_input_debouncer;

  localparam int SC = 4;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          a_raw = 1'b0;
  logic          a_clean;
  logic          rise;
  logic          fall;
  logic [GW-1:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  input_debouncer #(.STABLE_CYCLES(SC), .GLITCH_W(GW)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_raw      (a_raw),
    .a_clean    (a_clean),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FSM sees a_raw two samples late; a new level is committed
  // once it has been seen SC samples in a row, and any shorter run counts as a glitch.
  bit dly [2];
  bit m_lvl = 0, m_rise = 0, m_fall = 0;
  int m_run = 0;
  int m_glitch = 0;

  always @(posedge clk) begin
    bit s;
    if (!reset) begin
      dly[0] = 0; dly[1] = 0;
      m_lvl = 0; m_run = 0; m_glitch = 0; m_rise = 0; m_fall = 0;
    end else begin
      s = dly[1];
      m_rise = 0; m_fall = 0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == SC) begin
          m_lvl = s;
          m_run = 0;
          if (s) m_rise = 1; else m_fall = 1;
        end
      end else if (m_run > 0) begin
        if (m_glitch < (1 << GW) - 1) m_glitch++;
        m_run = 0;
      end
      dly[1] = dly[0];
      dly[0] = a_raw;
    end
  end

  bit check_en = 0;
  int rise_count = 0;
  int fall_count = 0;

  always @(negedge clk) begin
    if (check_en) begin
      chk("a_clean", int'(a_clean), int'(m_lvl));
      chk("rise", int'(rise), int'(m_rise));
      chk("fall", int'(fall), int'(m_fall));
      chk("glitch_cnt", int'(glitch_cnt), m_glitch);
      if (rise && fall) chk("rise_fall_exclusive", 1, 0);
      if (rise) rise_count++;
      if (fall) fall_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r0, f0, g0;
    step(3);
    check_en = 1;

    // Reset held with a_raw=1, released so the next edge is E0.
    a_raw = 1;
    step(2);
    reset = 1;
    step(5);
    chk("t1_clean_before_E5", int'(a_clean), 0);
    step(1);
    chk("t1_clean_after_E5", int'(a_clean), 1);
    chk("t1_rise_after_E5", int'(rise), 1);
    chk("t1_model_clean", int'(m_lvl), 1);
    step(1);
    chk("t1_rise_one_cycle", int'(rise), 0);

    // From HIGH: long low period gives exactly one fall.
    r0 = rise_count; f0 = fall_count;
    a_raw = 0;
    step(10);
    chk("t3_fall_count", fall_count - f0, 1);
    chk("t3_rise_count", rise_count - r0, 0);
    chk("t3_glitch", int'(glitch_cnt), 0);
    chk("t3_clean", int'(a_clean), 0);

    // From LOW: three-cycle high pulse is filtered.
    r0 = rise_count;
    a_raw = 1; step(3);
    a_raw = 0; step(8);
    chk("t2_glitch", int'(glitch_cnt), 1);
    chk("t2_model_glitch", m_glitch, 1);
    chk("t2_rise_count", rise_count - r0, 0);
    chk("t2_clean", int'(a_clean), 0);

    // Bounce train 1,0,1,0 then steady high.
    r0 = rise_count;
    a_raw = 1; step(1);
    a_raw = 0; step(1);
    a_raw = 1; step(1);
    a_raw = 0; step(1);
    a_raw = 1; step(10);
    chk("t4_rise_count", rise_count - r0, 1);
    chk("t4_glitch", int'(glitch_cnt), 3);
    chk("t4_clean", int'(a_clean), 1);

    // 300 aborted waits saturate the glitch counter.
    repeat (300) begin
      a_raw = 0; step(1);
      a_raw = 1; step(1);
    end
    step(4);
    chk("t5_glitch_sat", int'(glitch_cnt), 255);
    repeat (10) begin
      a_raw = 0; step(1);
      a_raw = 1; step(1);
    end
    step(10);
    chk("t5_glitch_hold", int'(glitch_cnt), 255);
    chk("t5_model_glitch", m_glitch, 255);

    // Reset in WAIT_LOW with cnt=2.
    a_raw = 0;
    step(4);
    chk("t6_clean_pre", int'(a_clean), 1);
    reset = 0;
    step(1);
    chk("t6_clean", int'(a_clean), 0);
    chk("t6_rise", int'(rise), 0);
    chk("t6_fall", int'(fall), 0);
    chk("t6_glitch", int'(glitch_cnt), 0);
    reset = 1;
    step(1);
    chk("t6_no_pulse", int'(rise | fall), 0);

    // Random run lengths around the threshold, with occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 0;
        step($urandom_range(1, 2));
        reset = 1;
      end
      a_raw = ~a_raw;
      step($urandom_range(1, 7));
    end
    step(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
